reg_file_mp: RTL

//  Parametrised multi-port register file for the pipelined MIPS datapath: NUM_RD

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_clear_fsm.sv | 80 ++++++++
 rtl/reg_file_mp.sv | 101 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file and its clear engine.
package reg_file_pkg;

    // Clear engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;

    // True when an address selects the hard-wired zero entry
    function automatic logic is_zero_entry(input logic zero_en, input logic [31:0] addr);
        return zero_en && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Bulk-clear sequencer: sweeps one entry per cycle and blocks writes while active.
//
// state | meaning
// IDLE  | waiting for clr_req_i, writes allowed
// CLEAR | zeroing entry idx_q, writes blocked, clr_busy_o high
// DONE  | one-cycle completion pulse, writes allowed again
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_idx_o,
    output logic          wr_ready_o
);

    clr_state_t    state_q;
    logic [AW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;

    // State, sweep index and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clr_req_i) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = busy_q;
    assign clr_idx_o  = idx_q;
    assign wr_ready_o = ready_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (port 1 wins on address collision), optional zero entry, bulk-clear engine.
// Build option REG_FILE_BYPASS_EN: an accepted write is forwarded to any read
// port addressing the same entry in the same cycle.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int DW       = DEF_DW,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD*DW-1:0] rd_data_o,
    input  logic [1:0]           wr_en_i,
    input  logic [2*AW-1:0]      wr_addr_i,
    input  logic [2*DW-1:0]      wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 clr_req_i,
    output logic                 clr_busy_o,
    output logic                 clr_done_o
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic [AW-1:0] wa [2];
    logic [DW-1:0] wd [2];
    logic [1:0]    wr_go;

    logic          clr_we;
    logic [AW-1:0] clr_idx;
    logic          wr_ready;

    reg_file_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o),
        .clr_done_o (clr_done_o),
        .clr_we_o   (clr_we),
        .clr_idx_o  (clr_idx),
        .wr_ready_o (wr_ready)
    );

    assign wr_ready_o = wr_ready;

    // Split write ports and qualify them; writes to the zero entry never land
    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign wa[p]    = wr_addr_i[p*AW +: AW];
        assign wd[p]    = wr_data_i[p*DW +: DW];
        assign wr_go[p] = wr_ready && wr_en_i[p] && !is_zero_entry(ZERO_EN, 32'(wa[p]));
    end

    // Next storage contents: port 0, then port 1 overriding, then the sweep
    always_comb begin
        mem_d = mem_q;
        if (wr_go[0]) mem_d[wa[0]] = wd[0];
        if (wr_go[1]) mem_d[wa[1]] = wd[1];
        if (clr_we)   mem_d[clr_idx] = '0;
        if (ZERO_EN)  mem_d[0] = '0;
    end

    // Storage array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read muxes, one per port
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rdata;

        assign ra = rd_addr_i[k*AW +: AW];

        // Stored value, optionally overridden by a same-cycle write
        always_comb begin
            rdata = mem_q[ra];
`ifdef REG_FILE_BYPASS_EN
            if (wr_go[0] && (wa[0] == ra)) rdata = wd[0];
            if (wr_go[1] && (wa[1] == ra)) rdata = wd[1];
`endif
            if (is_zero_entry(ZERO_EN, 32'(ra))) rdata = '0;
        end

        assign rd_data_o[k*DW +: DW] = rdata;
    end

endmodule
